byte_word_packer: RTL and testbench

Packs a stream of SYM_W-bit symbols into SYMS-symbol words, with valid/ready flow control on both sides. It is the parametrised successor to our fixed byte-to-word assembler. It adds selectable lane order, early flush of a partial word via in_last with a per-lane keep mask, and a registered output slot that holds its data under backpressure. It sits between byte-oriented sources (UART/SPI receivers, byte FIFOs) and word-wide consumers (register files, bus masters).

---
 rtl/byte_word_packer.sv | 106 ++++++++++
 tb/tb_byte_word_packer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_word_packer.sv
// byte_word_packer
//   Packs a stream of SYM_W-bit symbols into SYMS-symbol words. The first
//   symbol of a word lands in lane 0 (LSB_FIRST=1) or lane SYMS-1
//   (LSB_FIRST=0). in_last closes a word early. The completed word sits in a
//   registered output slot that holds steady under backpressure.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_data / in_last valid this cycle
//   in_ready   block can accept a symbol this cycle
//   in_data    input symbol
//   in_last    accepted symbol ends a packet (closes the word early)
//   out_valid  out_data / out_keep / out_last hold a complete word
//   out_ready  consumer takes the word this cycle
//   out_data   assembled word; lanes never written are zero
//   out_keep   one bit per lane holding a valid symbol
//   out_last   word ends a packet
module byte_word_packer #(
    parameter int SYM_W     = 8,
    parameter int SYMS      = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SYM_W-1:0]      in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SYMS*SYM_W-1:0] out_data,
    output logic [SYMS-1:0]       out_keep,
    output logic                  out_last
);

    localparam int CNT_W = ($clog2(SYMS) > 1) ? $clog2(SYMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMS - 1);

    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      lane;
    logic [SYMS*SYM_W-1:0] acc;
    logic [SYMS*SYM_W-1:0] acc_next;
    logic [SYMS-1:0]       acc_keep;
    logic [SYMS-1:0]       keep_next;
    logic                  in_fire;
    logic                  out_fire;
    logic                  closing;

    // The slot can take a new word when it is empty or being drained now.
    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign closing  = in_fire && (in_last || (cnt == LAST_CNT));

    always_comb begin
        lane = (LSB_FIRST != 0) ? cnt : (LAST_CNT - cnt);
    end

    // Accumulator and keep mask with the current symbol merged in; used both
    // for the running partial word and for the word loaded into the slot.
    always_comb begin
        acc_next  = acc;
        keep_next = acc_keep;
        for (int unsigned i = 0; i < SYMS; i++) begin
            if (CNT_W'(i) == lane) begin
                acc_next[i*SYM_W +: SYM_W] = in_data;
                keep_next[i]               = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            acc_keep  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (in_fire) begin
                if (closing) begin
                    out_data <= acc_next;
                    out_keep <= keep_next;
                    out_last <= in_last;
                    acc      <= '0;
                    acc_keep <= '0;
                    cnt      <= '0;
                end else begin
                    acc      <= acc_next;
                    acc_keep <= keep_next;
                    cnt      <= cnt + 1'b1;
                end
            end
            // A close reloads the slot even when it drains on the same edge.
            if (closing) begin
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready_l, in_ready_m;
    logic        out_valid_l, out_valid_m;
    logic [31:0] out_data_l, out_data_m;
    logic [3:0]  out_keep_l, out_keep_m;
    logic        out_last_l, out_last_m;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int or_mode  = 0;   // 0: out_ready=1, 1: out_ready=0, 2: random

    word_t q_l[$];
    word_t q_m[$];

    // bench model of the partial word, both lane orders
    int unsigned mcnt = 0;
    logic [31:0] macc_l = '0, macc_m = '0;
    logic [3:0]  mkeep_l = '0, mkeep_m = '0;

    byte_word_packer #(.SYM_W(8), .SYMS(4), .LSB_FIRST(1)) dut_l (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_l),
        .out_ready(out_ready), .out_data(out_data_l), .out_keep(out_keep_l),
        .out_last(out_last_l)
    );

    byte_word_packer #(.SYM_W(8), .SYMS(4), .LSB_FIRST(0)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_m),
        .out_ready(out_ready), .out_data(out_data_m), .out_keep(out_keep_m),
        .out_last(out_last_m)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    function automatic void model_clear();
        mcnt    = 0;
        macc_l  = '0;
        macc_m  = '0;
        mkeep_l = '0;
        mkeep_m = '0;
    endfunction

    function automatic void model_accept(input logic [7:0] d, input logic last);
        int unsigned ll = mcnt;
        int unsigned lm = 3 - mcnt;
        word_t w;
        macc_l[ll*8 +: 8] = d;
        macc_m[lm*8 +: 8] = d;
        mkeep_l[ll] = 1'b1;
        mkeep_m[lm] = 1'b1;
        if (last || mcnt == 3) begin
            w.data = macc_l; w.keep = mkeep_l; w.last = last; q_l.push_back(w);
            w.data = macc_m; w.keep = mkeep_m; w.last = last; q_m.push_back(w);
            model_clear();
        end else begin
            mcnt++;
        end
    endfunction

    // Offers one symbol and waits (bounded) until it is accepted.
    task automatic send(input logic [7:0] d, input logic last);
        int guard = 0;
        bit ok = 1'b1;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready_l) break;
            guard++;
            if (guard > 1000) begin
                check("send_timeout", 64'd0, 64'd1);
                ok = 1'b0;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            model_accept(d, last);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        q_l.delete();
        q_m.delete();
        check("rst_valid_l", out_valid_l, 1'b0);
        check("rst_valid_m", out_valid_m, 1'b0);
        check("rst_data_l", out_data_l, 32'h0);
        check("rst_keep_l", out_keep_l, 4'h0);
        check("rst_last_l", out_last_l, 1'b0);
        check("rst_data_m", out_data_m, 32'h0);
    endtask

    // Scoreboard monitor plus hold-under-backpressure check.
    word_t held_l;
    bit    stall_prev = 1'b0;
    always @(negedge clk) begin
        word_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_data", out_data_l, held_l.data);
                check("hold_keep", out_keep_l, held_l.keep);
                check("hold_last", out_last_l, held_l.last);
            end
            if (out_valid_l && out_ready) begin
                if (q_l.size() == 0) begin
                    check("unexpected_word_l", out_data_l, 64'hDEAD);
                end else begin
                    e = q_l.pop_front();
                    check("sb_data_l", out_data_l, e.data);
                    check("sb_keep_l", out_keep_l, e.keep);
                    check("sb_last_l", out_last_l, e.last);
                end
            end
            if (out_valid_m && out_ready) begin
                if (q_m.size() == 0) begin
                    check("unexpected_word_m", out_data_m, 64'hDEAD);
                end else begin
                    e = q_m.pop_front();
                    check("sb_data_m", out_data_m, e.data);
                    check("sb_keep_m", out_keep_m, e.keep);
                    check("sb_last_m", out_last_m, e.last);
                end
            end
            stall_prev  = out_valid_l && !out_ready;
            held_l.data = out_data_l;
            held_l.keep = out_keep_l;
            held_l.last = out_last_l;
        end
    end

    initial begin
        int t0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // basic pack, both lane orders
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        check("basic_not_early", out_valid_l, 1'b0);
        send(8'h44, 1'b0);
        check("basic_latency", out_valid_l, 1'b1);
        check("basic_data_l", out_data_l, 32'h44332211);
        check("basic_data_m", out_data_m, 32'h11223344);
        check("basic_keep", out_keep_l, 4'b1111);
        check("basic_last", out_last_l, 1'b0);

        // early flush
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        check("flush_data_l", out_data_l, 32'h0000BBAA);
        check("flush_keep_l", out_keep_l, 4'b0011);
        check("flush_data_m", out_data_m, 32'hAABB0000);
        check("flush_keep_m", out_keep_m, 4'b1100);
        check("flush_last", out_last_l, 1'b1);

        // last on the final lane: full word with last
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b1);
        check("full_last_keep", out_keep_l, 4'b1111);
        check("full_last_last", out_last_l, 1'b1);

        // backpressure
        or_mode = 1;
        @(posedge clk);
        #1;
        send(8'h21, 1'b0);
        send(8'h22, 1'b0);
        send(8'h23, 1'b0);
        send(8'h24, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_last  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", in_ready_l, 1'b0);
            check("bp_out_data", out_data_l, 32'h24232221);
        end
        or_mode = 0;
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b1);
        check("bp_after_data", out_data_l, 32'h00776655);
        check("bp_after_keep", out_keep_l, 4'b0111);

        // streaming: 12 symbols in 12 cycles
        t0 = cyc;
        for (int i = 1; i <= 12; i++) send(8'(i), 1'b0);
        check("stream_cycles", cyc - t0, 12);
        check("stream_last_word", out_data_l, 32'h0C0B0A09);

        // reset mid-word
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b0);
        check("post_rst_word_l", out_data_l, 32'h13121110);
        check("post_rst_word_m", out_data_m, 32'h10111213);

        // random traffic with random backpressure
        or_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send(8'($urandom), ($urandom_range(0, 5) == 0));
        end

        // drain
        or_mode = 0;
        if (mcnt != 0) send(8'hEE, 1'b1);
        repeat (6) @(negedge clk);
        check("drain_q_l", q_l.size(), 0);
        check("drain_q_m", q_m.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
